// File: rtl/friscv_muldiv_pkg.sv
// Shared RV32M definitions for the iterative multiply/divide unit.
package friscv_muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } MULDIV_OPS;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } muldiv_state_e;

  localparam logic [6:0] FUNCT7_MULDIV  = 7'b0000001;
  localparam int         MULDIV_XLEN    = 32;
  localparam int         MULDIV_LATENCY = MULDIV_XLEN + 1;

  function automatic int muldiv_latency(input int xlen);
    return xlen + 1;
  endfunction

endpackage

// File: rtl/friscv_muldiv_if.sv
// Request/response handshake between the execute stage and the mul/div unit.
interface friscv_muldiv_if #(
  parameter int XLEN = 32
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            kill_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [XLEN-1:0] result_o;
  logic            busy_o;

  modport master (
    output req_valid_i, op_i, rs1_i, rs2_i, kill_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, result_o, busy_o
  );

  modport slave (
    input  req_valid_i, op_i, rs1_i, rs2_i, kill_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, result_o, busy_o
  );
endinterface

// File: rtl/friscv_muldiv.sv
// Iterative RV32M multiply/divide: one result bit per cycle through a single
// shared adder/subtractor operating on operand magnitudes.
module friscv_muldiv
  import friscv_muldiv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FAST_SPECIAL = 1
) (
  input logic            clk,
  input logic            rst_n,
  friscv_muldiv_if.slave bus
);

  localparam int CW = $clog2(XLEN + 1);

  muldiv_state_e   state, next_state;
  MULDIV_OPS       op_q, op_in;
  logic [XLEN-1:0] acc, lo, bmag, spec_res, result_q;
  logic            neg_q, neg_r, spec_q;
  logic [CW-1:0]   cnt;

  logic            a_neg, b_neg, div_zero, div_ovf, special_in, accept, is_div;
  logic [XLEN-1:0] a_mag, b_mag, spec_in, final_val;
  logic [XLEN:0]   add_a, add_b, add_res, mul_step;
  logic [2*XLEN-1:0] prod;

  assign op_in      = MULDIV_OPS'(bus.op_i);
  assign a_neg      = bus.rs1_i[XLEN-1] & (op_in inside {MUL, MULH, MULHSU, DIV, REM});
  assign b_neg      = bus.rs2_i[XLEN-1] & (op_in inside {MUL, MULH, DIV, REM});
  assign a_mag      = a_neg ? -bus.rs1_i : bus.rs1_i;
  assign b_mag      = b_neg ? -bus.rs2_i : bus.rs2_i;
  assign div_zero   = bus.op_i[2] & (bus.rs2_i == '0);
  assign div_ovf    = (op_in inside {DIV, REM}) & (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}})
                      & (bus.rs2_i == '1);
  assign special_in = div_zero | div_ovf;
  // op_i[1] separates REM/REMU from DIV/DIVU among the divide opcodes
  assign spec_in    = div_zero ? (bus.op_i[1] ? bus.rs1_i : '1)
                               : (bus.op_i[1] ? '0 : bus.rs1_i);
  assign accept     = bus.req_valid_i & (state == IDLE) & ~bus.kill_i;

  // Shared adder: adds the multiplicand while multiplying, trial-subtracts
  // the divisor from the shifted partial remainder while dividing.
  assign is_div   = op_q inside {DIV, DIVU, REM, REMU};
  assign add_a    = is_div ? {acc, lo[XLEN-1]} : {1'b0, acc};
  assign add_b    = {1'b0, bmag};
  assign add_res  = is_div ? (add_a - add_b) : (add_a + add_b);
  assign mul_step = lo[0] ? add_res : {1'b0, acc};

  assign prod = neg_q ? -{acc, lo} : {acc, lo};

  always_comb begin
    final_val = '0;
    if (spec_q) begin
      final_val = spec_res;
    end else begin
      case (op_q)
        MUL:                 final_val = prod[XLEN-1:0];
        MULH, MULHSU, MULHU: final_val = prod[2*XLEN-1:XLEN];
        DIV, DIVU:           final_val = neg_q ? -lo : lo;
        default:             final_val = neg_r ? -acc : acc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = CALC;
      CALC:    if (cnt == '0) next_state = DONE;
      DONE:    if (bus.rsp_ready_i) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (bus.kill_i) next_state = IDLE;
  end

  // Special cases load a zero count so CALC finalises on the very next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= MUL;
      acc      <= '0;
      lo       <= '0;
      bmag     <= '0;
      spec_res <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      spec_q   <= 1'b0;
      cnt      <= '0;
    end else if (accept) begin
      op_q     <= op_in;
      acc      <= '0;
      lo       <= a_mag;
      bmag     <= b_mag;
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      spec_q   <= special_in;
      spec_res <= spec_in;
      cnt      <= (special_in && FAST_SPECIAL != 0) ? CW'(0) : CW'(XLEN);
    end else if (state == CALC && !bus.kill_i) begin
      if (cnt != '0) begin
        cnt <= cnt - CW'(1);
        if (is_div) begin
          acc <= add_res[XLEN] ? add_a[XLEN-1:0] : add_res[XLEN-1:0];
          lo  <= {lo[XLEN-2:0], ~add_res[XLEN]};
        end else begin
          acc <= mul_step[XLEN:1];
          lo  <= {mul_step[0], lo[XLEN-1:1]};
        end
      end else begin
        result_q <= final_val;
      end
    end
  end

  assign bus.req_ready_o = (state == IDLE);
  assign bus.rsp_valid_o = (state == DONE);
  assign bus.busy_o      = (state == CALC) || (state == DONE);
  assign bus.result_o    = result_q;

endmodule
